// File: rtl/cgra_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_pkg
//  Description : Shared types and frame field layout for the CGRA config path.
//  Revision    : 1.0  initial release
// ============================================================================
package cgra_pkg;

  localparam int FRAME_WIDTH = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Bit positions of the fields inside one PE configuration frame
  localparam int FLD_OPCODE_LSB = 0;
  localparam int FLD_OPCODE_W   = 6;
  localparam int FLD_SRC0_LSB   = 6;
  localparam int FLD_SRC0_W     = 4;
  localparam int FLD_SRC1_LSB   = 10;
  localparam int FLD_SRC1_W     = 4;
  localparam int FLD_DST_LSB    = 14;
  localparam int FLD_DST_W      = 4;
  localparam int FLD_ROUTE_LSB  = 18;
  localparam int FLD_ROUTE_W    = 4;
  localparam int FLD_PRED_EN    = 22;
  localparam int FLD_PRED_INV   = 23;
  localparam int FLD_IMM_LSB    = 24;
  localparam int FLD_IMM_W      = 16;

endpackage
`default_nettype wire

// File: rtl/cgra_ctx_mem.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_ctx_mem
//  Description : Context frame store, synchronous write / asynchronous read.
//  Revision    : 1.0  initial release
// ============================================================================
module cgra_ctx_mem #(
  parameter  int FRAME_WIDTH = 64,
  parameter  int CTX_DEPTH   = 16,
  localparam int CTX_AW      = $clog2(CTX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [CTX_AW-1:0]      i_wr_addr,
  input  logic [FRAME_WIDTH-1:0] i_wr_data,
  input  logic [CTX_AW-1:0]      i_rd_addr,
  output logic [FRAME_WIDTH-1:0] o_rd_data
);

  // Deliberately unreset: contents are only meaningful once loaded
  logic [FRAME_WIDTH-1:0] r_mem [CTX_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/cgra_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cgra_cfg_sequencer
//  Description : Replays stored PE configuration frames, with loop/stall/abort.
//  Revision    : 1.0  initial release
// ============================================================================
module cgra_cfg_sequencer #(
  parameter  int FRAME_WIDTH = cgra_pkg::FRAME_WIDTH,
  parameter  int CTX_DEPTH   = 16,
  localparam int CTX_AW      = $clog2(CTX_DEPTH),
  parameter  int LOOP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [CTX_AW-1:0]      wr_addr,
  input  logic [FRAME_WIDTH-1:0] wr_data,
  input  logic                   start,
  input  logic [CTX_AW:0]        num_frames,
  input  logic [LOOP_WIDTH-1:0]  loop_count,
  input  logic                   stall,
  input  logic                   abort,
  output logic [FRAME_WIDTH-1:0] config_frame,
  output logic                   config_valid,
  output logic [CTX_AW-1:0]      frame_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  import cgra_pkg::*;

  localparam logic [CTX_AW:0]       C_DEPTH  = (CTX_AW+1)'(CTX_DEPTH);
  localparam logic [CTX_AW-1:0]     C_ONE_P  = CTX_AW'(1);
  localparam logic [LOOP_WIDTH-1:0] C_ONE_L  = LOOP_WIDTH'(1);

  seq_state_t             r_state, w_state_nxt;
  logic [CTX_AW-1:0]      r_ptr, w_ptr_nxt;
  logic [CTX_AW:0]        r_num, w_num_nxt;
  logic [LOOP_WIDTH-1:0]  r_pass, w_pass_nxt;
  logic                   r_last, w_last_nxt;
  logic [FRAME_WIDTH-1:0] r_frame, w_frame_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [CTX_AW-1:0]      r_idx, w_idx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;

  logic                   w_mem_we;
  logic [CTX_AW-1:0]      w_rd_addr;
  logic [FRAME_WIDTH-1:0] w_rd_data;
  logic [CTX_AW:0]        w_cur_num;
  logic [LOOP_WIDTH-1:0]  w_cur_pass;
  logic                   w_end_of_pass;
  logic [CTX_AW-1:0]      w_adv_ptr;
  logic [LOOP_WIDTH-1:0]  w_adv_pass;
  logic                   w_adv_last;
  logic                   w_start_legal;

  assign w_mem_we = wr_en && (r_state == IDLE);

  cgra_ctx_mem #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .CTX_DEPTH   (CTX_DEPTH)
  ) u_ctx_mem (
    .clk       (clk),
    .i_we      (w_mem_we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // The start edge issues slot 0 using the freshly presented num/loop inputs,
  // so the pointer-advance logic below is shared between start and RUN.
  assign w_rd_addr     = (r_state == RUN) ? r_ptr  : '0;
  assign w_cur_num     = (r_state == RUN) ? r_num  : num_frames;
  assign w_cur_pass    = (r_state == RUN) ? r_pass : loop_count;
  assign w_end_of_pass = (({1'b0, w_rd_addr} + {1'b0, C_ONE_P}) == w_cur_num);
  assign w_adv_ptr     = w_end_of_pass ? '0 : (w_rd_addr + C_ONE_P);
  assign w_adv_pass    = (w_end_of_pass && (w_cur_pass != '0)) ? (w_cur_pass - C_ONE_L)
                                                               : w_cur_pass;
  assign w_adv_last    = w_end_of_pass && (w_cur_pass == '0);
  assign w_start_legal = (num_frames != '0) && (num_frames <= C_DEPTH);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_num_nxt   = r_num;
    w_pass_nxt  = r_pass;
    w_last_nxt  = r_last;
    w_frame_nxt = r_frame;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    if (r_state == IDLE) begin
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      if (start && !abort) begin
        if (w_start_legal) begin
          w_state_nxt = RUN;
          w_num_nxt   = num_frames;
          w_frame_nxt = w_rd_data;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_adv_ptr;
          w_pass_nxt  = w_adv_pass;
          w_last_nxt  = w_adv_last;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
    end else begin
      if (abort) begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = '0;
        w_num_nxt   = '0;
        w_pass_nxt  = '0;
        w_last_nxt  = 1'b0;
      end else if (stall) begin
        w_valid_nxt = 1'b0;
      end else if (!r_last) begin
        w_frame_nxt = w_rd_data;
        w_idx_nxt   = r_ptr;
        w_valid_nxt = 1'b1;
        w_ptr_nxt   = w_adv_ptr;
        w_pass_nxt  = w_adv_pass;
        w_last_nxt  = w_adv_last;
      end else begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_ptr_nxt   = '0;
        w_num_nxt   = '0;
        w_pass_nxt  = '0;
        w_last_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_num   <= '0;
      r_pass  <= '0;
      r_last  <= 1'b0;
      r_frame <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_num   <= w_num_nxt;
      r_pass  <= w_pass_nxt;
      r_last  <= w_last_nxt;
      r_frame <= w_frame_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign config_frame = r_frame;
  assign config_valid = r_valid;
  assign frame_idx    = r_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: doc/cgra_cfg_sequencer.md
Name: cgra_cfg_sequencer

Overview:
- Upstream configuration stage for cgra_pe.
- Holds a small context memory of 64-bit PE configuration frames, loaded by the host/loader.
- On start, replays the frames to the PE one per cycle on config_frame/config_valid, with optional looping, stall and abort.
- Output connects directly to cgra_pe.config_frame / config_valid.

Parameters:
- FRAME_WIDTH, 64, width of one configuration frame (matches cgra_pe config_frame).
- CTX_DEPTH, 16, number of frame slots in the context memory (power of two).
- CTX_AW, $clog2(CTX_DEPTH), slot address width (derived; do not override).
- LOOP_WIDTH, 8, width of the loop-count field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one frame into the context memory.
- wr_addr  in  CTX_AW  slot written when wr_en.
- wr_data  in  FRAME_WIDTH  frame data written.
- start  in  1  begin playback (sampled in IDLE only).
- num_frames  in  CTX_AW+1  frames per pass; legal range 1..CTX_DEPTH; sampled at start.
- loop_count  in  LOOP_WIDTH  extra passes (0 = play once); sampled at start.
- stall  in  1  suppress issue of a new frame at this edge.
- abort  in  1  terminate playback.
- config_frame  out  FRAME_WIDTH  frame presented to the PE.
- config_valid  out  1  config_frame is valid this cycle.
- frame_idx  out  CTX_AW  slot index of the presented frame.
- busy  out  1  sequencer in RUN.
- done  out  1  one-cycle pulse after the final frame of the final pass.
- err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- Reset (async, rst=1): state IDLE; config_frame=0, config_valid=0, frame_idx=0, busy=0, done=0, err=0; ptr and pass counters cleared.
  - Context memory is not reset; contents are undefined until written.
- States: IDLE, RUN. All outputs are registered.
- Writes: wr_en in IDLE writes mem[wr_addr] at the edge. wr_en while busy is ignored (memory unchanged).
- Read: combinational from the array. A write and a read of the same slot at the same edge returns the OLD value.
- Start (IDLE, start=1, abort=0) with num_frames in 1..CTX_DEPTH:
  - At that edge: latch num_frames and loop_count; config_frame<=mem[0], frame_idx<=0, config_valid<=1; ptr<=1 (or 0 if num_frames=1 and loops remain); state<=RUN; busy<=1.
  - Latency: first valid frame appears the cycle after start is sampled.
- Illegal start (num_frames=0 or >CTX_DEPTH): stay IDLE, err<=1 for one cycle, no valid output.
- RUN, each edge, in priority order:
  - abort=1: state<=IDLE, config_valid<=0, busy<=0. No done. Counters cleared.
  - stall=1: config_valid<=0; ptr and pass counter hold. config_frame and frame_idx hold their last values.
  - Frames remaining: issue mem[ptr] with config_valid<=1 and frame_idx<=ptr.
    - ptr wraps from num_frames-1 to 0 and decrements the remaining-pass count.
  - All frames issued: config_valid<=0, busy<=0, done<=1, state<=IDLE.
- Total valid cycles = num_frames*(loop_count+1) exactly, regardless of stalls. Stalls only insert config_valid=0 gaps.
- start while busy is ignored. start+abort in IDLE: abort wins (no playback, no err).
- done, err: single-cycle pulses, cleared the following edge.
- Reset mid-RUN: immediate return to reset values; no done pulse.

Decomposition:
- Shared package cgra_pkg:
  - FRAME_WIDTH constant (shared with cgra_pe).
  - seq_state_t enum {IDLE, RUN}.
  - Frame field-position constants (opcode[5:0], src0[9:6], src1[13:10], dst[17:14], route[21:18], pred_en[22], pred_inv[23], imm[39:24]) for benches and loaders.
- One sub-module: cgra_ctx_mem, a CTX_DEPTH x FRAME_WIDTH register array with synchronous write and asynchronous read.

Test Plan:
- Load slots 0..2 with opcodes ADD/MUL/PASS0 (imm 10/5/0xABCD); start with num_frames=3, loop_count=0, no stall → config_valid high 3 consecutive cycles starting 1 cycle after start; frame_idx 0,1,2; done pulses the next cycle.
- Same load, loop_count=2 → 9 valid cycles; frame_idx sequence 0,1,2,0,1,2,0,1,2; single done pulse.
- num_frames=3, stall high for 2 edges after the first frame → valid pattern 1,0,0,1,1; frame_idx stays 0 during the gap; still exactly 3 valid frames, then done.
- abort asserted at the 2nd RUN edge of a 4-frame run → config_valid drops next cycle, busy=0, no done. A new start then replays from frame 0.
- start with num_frames=0, then with num_frames=17 → err pulses each time, config_valid stays 0. wr_en to slot 0 with value 0x1 during RUN → slot unchanged on next playback.
- rst asserted mid-run (asynchronous, between edges) → all outputs 0 immediately; after release the sequencer stays in IDLE until start.
